// File: rtl/game_frame_buffer.sv
// game_frame_buffer: one-deep buffer that swaps a new game state onto the display only at a vertical-sync boundary
package game_state_pkg;
    typedef struct packed {
        logic [9:0][19:0] screen;
    } game_state_t;
endpackage

module game_frame_buffer #(
    parameter int COUNT_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         game_state_valid,
    input  game_state_pkg::game_state_t  game_state,
    output logic                         game_state_ready,
    input  logic                         VGA_new_frame_ready,
    output game_state_pkg::game_state_t  VGA_frame,
    output logic                         frame_committed,
    output logic [COUNT_BITS-1:0]        frame_count,
    output logic [COUNT_BITS-1:0]        repeat_count
);
    typedef enum logic {EMPTY, PENDING} state_t;
    state_t state, state_next;
    game_state_pkg::game_state_t pending;
    logic nfr_q, frame_edge, accept, commit;
    always_comb begin
        frame_edge       = VGA_new_frame_ready & ~nfr_q;
        game_state_ready = (state == EMPTY);
        accept           = game_state_valid & game_state_ready;
        commit           = frame_edge & (state == PENDING);
        state_next       = (state == EMPTY) ? (accept ? PENDING : EMPTY) : (frame_edge ? EMPTY : PENDING);
    end
    // nfr_q resets high so a sync window already open at release is not a boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= EMPTY;
            pending         <= '0;
            VGA_frame       <= '0;
            frame_committed <= 1'b0;
            frame_count     <= '0;
            repeat_count    <= '0;
            nfr_q           <= 1'b1;
        end else begin
            state           <= state_next;
            nfr_q           <= VGA_new_frame_ready;
            frame_committed <= commit;
            if (accept)
                pending <= game_state;
            if (commit) begin
                VGA_frame   <= pending;
                frame_count <= frame_count + 1'b1;
            end
            if (frame_edge && state == EMPTY && repeat_count != '1)
                repeat_count <= repeat_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_game_frame_buffer.sv
// tb_game_frame_buffer: directed stimulus with a commit scoreboard checked by an independent monitor
module tb_game_frame_buffer;
    import game_state_pkg::*;
    typedef struct {
        game_state_t f;
        logic [7:0]  c;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic game_state_valid = 1'b0;
    game_state_t game_state = '0;
    logic game_state_ready;
    logic VGA_new_frame_ready = 1'b1;
    game_state_t VGA_frame;
    logic frame_committed;
    logic [7:0] frame_count, repeat_count;
    exp_t q[$];
    logic [7:0] exp_fc = 8'd0;
    int total = 0;
    int bad = 0;
    game_state_t a, b, c, s;

    game_frame_buffer #(.COUNT_BITS(8)) dut (
        .clk(clk), .reset(reset),
        .game_state_valid(game_state_valid), .game_state(game_state),
        .game_state_ready(game_state_ready),
        .VGA_new_frame_ready(VGA_new_frame_ready),
        .VGA_frame(VGA_frame), .frame_committed(frame_committed),
        .frame_count(frame_count), .repeat_count(repeat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Producer side: an offer accepted at this edge becomes the next expected commit
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            if (game_state_valid && game_state_ready) begin
                exp_fc = exp_fc + 8'd1;
                q.push_back('{game_state, exp_fc});
                @(posedge clk);
                #1 game_state_valid = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset && frame_committed) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_commit: got frame %h want no commit", VGA_frame);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("commit_frame", VGA_frame, e.f);
                chk("commit_count", frame_count, e.c);
            end
        end
    end

    initial begin
        a = '0; a.screen[3][5] = 1'b1;
        b = '0; b.screen[9][19] = 1'b1; b.screen[0][0] = 1'b1;
        c = '0; c.screen[5][10] = 1'b1;
        // reset release while sync window already open
        tick(2);
        reset = 1'b0;
        tick(10);
        chk("rst_frame", VGA_frame, 0);
        chk("rst_ready", game_state_ready, 1);
        chk("rst_fc", frame_count, 0);
        chk("rst_rc", repeat_count, 0);
        chk("rst_commit", frame_committed, 0);
        // single commit of A
        VGA_new_frame_ready = 1'b0; tick();
        game_state = a; game_state_valid = 1'b1; tick();
        chk("a_ready_low", game_state_ready, 0);
        tick(2);
        chk("a_not_shown", VGA_frame, 0);
        VGA_new_frame_ready = 1'b1; tick();
        chk("a_shown", VGA_frame, a);
        chk("a_pulse", frame_committed, 1);
        tick(4);
        chk("a_pulse_once", frame_committed, 0);
        chk("a_fc", frame_count, 1);
        VGA_new_frame_ready = 1'b0; tick();
        // back-to-back offers: second stalls until first commits
        game_state = a; game_state_valid = 1'b1; tick();
        game_state = b; game_state_valid = 1'b1; tick(3);
        chk("b_stalled", game_state_ready, 0);
        VGA_new_frame_ready = 1'b1; tick();
        chk("ab_first", VGA_frame, a);
        chk("b_ready", game_state_ready, 1);
        tick();
        chk("b_accepted", game_state_ready, 0);
        tick(3);
        chk("b_waits_window", VGA_frame, a);
        VGA_new_frame_ready = 1'b0; tick(2);
        VGA_new_frame_ready = 1'b1; tick();
        chk("b_shown", VGA_frame, b);
        chk("ab_fc", frame_count, 3);
        VGA_new_frame_ready = 1'b0; tick();
        // idle boundaries
        for (int i = 0; i < 3; i++) begin
            VGA_new_frame_ready = 1'b1; tick(2);
            VGA_new_frame_ready = 1'b0; tick(2);
        end
        chk("idle_rc3", repeat_count, 3);
        chk("idle_frame", VGA_frame, b);
        chk("idle_fc", frame_count, 3);
        for (int i = 0; i < 300; i++) begin
            VGA_new_frame_ready = 1'b1; tick();
            VGA_new_frame_ready = 1'b0; tick();
        end
        chk("rc_saturate", repeat_count, 255);
        // reset while pending discards C
        game_state = c; game_state_valid = 1'b1; tick();
        chk("c_pending", game_state_ready, 0);
        #2 reset = 1'b1;
        q.delete();
        exp_fc = 8'd0;
        #1;
        chk("arst_frame", VGA_frame, 0);
        chk("arst_ready", game_state_ready, 1);
        chk("arst_fc", frame_count, 0);
        chk("arst_rc", repeat_count, 0);
        tick(2);
        reset = 1'b0;
        chk("rel_ready", game_state_ready, 1);
        tick(2);
        // offer coincides with boundary: held for the following window
        VGA_new_frame_ready = 1'b1;
        game_state = a; game_state_valid = 1'b1; tick();
        chk("coin_not_shown", VGA_frame, 0);
        chk("coin_rc", repeat_count, 1);
        tick(2);
        chk("coin_still_hidden", VGA_frame, 0);
        VGA_new_frame_ready = 1'b0; tick();
        VGA_new_frame_ready = 1'b1; tick();
        chk("coin_shown", VGA_frame, a);
        VGA_new_frame_ready = 1'b0; tick();
        // frame_count wraps after 256 total commits
        for (int i = 0; i < 255; i++) begin
            s = '0;
            s.screen[i % 10][(i * 7) % 20] = 1'b1;
            s.screen[(i / 10) % 10][19] = 1'b1;
            game_state = s; game_state_valid = 1'b1; tick();
            VGA_new_frame_ready = 1'b1; tick();
            VGA_new_frame_ready = 1'b0; tick();
        end
        tick(2);
        chk("fc_wrap", frame_count, 0);
        chk("rc_after_wrap", repeat_count, 1);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/game_frame_buffer.md
GAME_FRAME_BUFFER -- requirements
Module: game_frame_buffer

Interface
REQ-001 Parameter: COUNT_BITS, 8, width of the frame_count and repeat_count counters.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: game_state_valid  input  1  game logic offers a new game state this cycle.
REQ-005 Port: game_state  input  game_state_pkg::game_state_t  offered state (10x20 cell screen, screen[x][y]).
REQ-006 Port: game_state_ready  output  1  buffer can accept game_state this cycle.
REQ-007 Port: VGA_new_frame_ready  input  1  from the display decoder; high during vertical sync (inverted v_sync).
REQ-008 Port: VGA_frame  output  game_state_pkg::game_state_t  state currently displayed.
REQ-009 Port: frame_committed  output  1  one-cycle pulse when VGA_frame is updated.
REQ-010 Port: frame_count  output  COUNT_BITS  number of commits, wrapping.
REQ-011 Port: repeat_count  output  COUNT_BITS  frame boundaries with nothing pending, saturating.

Function
REQ-012 Internal state SHALL be one pending register (game_state_t), a state machine {EMPTY, PENDING}, and a registered copy of VGA_new_frame_ready (nfr_q).
REQ-013 game_state_ready SHALL be combinational: high iff state == EMPTY.
REQ-014 Accept: valid & ready in EMPTY -> pending <= game_state, state -> PENDING, on the next edge.
REQ-015 In PENDING, game_state_valid SHALL be ignored and the pending register SHALL hold; the producer holds its data until ready.
REQ-016 Boundary event: frame_edge = VGA_new_frame_ready & ~nfr_q (rising edge only); at most one event per vertical-sync window.
REQ-017 frame_edge in PENDING -> VGA_frame <= pending, state -> EMPTY, frame_committed = 1 for exactly the next cycle, frame_count += 1 (wraps from 2^COUNT_BITS-1 to 0).
REQ-018 frame_edge in EMPTY -> VGA_frame unchanged, no pulse, repeat_count += 1, saturating at 2^COUNT_BITS-1.
REQ-019 Simultaneous frame_edge and accept in EMPTY: data goes to pending only (no bypass), state -> PENDING, repeat_count += 1; commit waits for the next frame_edge.
REQ-020 VGA_new_frame_ready held high for many cycles SHALL produce exactly one frame_edge; data accepted later in the same window SHALL wait for the next window.
REQ-021 VGA_frame SHALL change only on a commit cycle, never mid-frame (VGA_new_frame_ready low).
REQ-022 Commit latency: VGA_frame reflects pending one clock after the cycle in which frame_edge is true.
REQ-023 frame_committed SHALL be registered (no combinational path from inputs).

Reset
REQ-024 Asynchronous assertion of reset SHALL immediately force: state EMPTY, pending all zeros, VGA_frame all zeros (blank screen), frame_committed 0, frame_count 0, repeat_count 0, nfr_q 1.
REQ-025 With nfr_q reset to 1, a VGA_new_frame_ready already high at reset release SHALL NOT produce a frame_edge; the first edge requires a low-to-high transition.
REQ-026 Reset during PENDING SHALL discard the pending state; game_state_ready SHALL be high in the first cycle after release.

Verification
REQ-027 Reset release with VGA_new_frame_ready=1, no input -> VGA_frame=0, ready=1, no frame_committed, both counters 0 after 10 cycles.
REQ-028 Offer state A (cell [3][5] set) with VGA_new_frame_ready low, then pulse it high for 5 cycles -> ready drops after accept; VGA_frame=A one cycle after the rising edge; one frame_committed pulse; frame_count=1.
REQ-029 Offer A then B back-to-back while VGA_new_frame_ready low -> B stalled (ready=0); first edge commits A; B accepted next cycle; second edge commits B; frame_count=2.
REQ-030 Three frame edges with no input offered -> VGA_frame unchanged, repeat_count=3, frame_count=0; 300 edges -> repeat_count=255.
REQ-031 Offer A in the exact cycle of a rising edge -> A pending, not displayed; displayed only after the following edge; repeat_count=1.
REQ-032 Assert reset while PENDING with state C -> VGA_frame=0, C never displayed, ready=1 after release, counters 0.
